// File: rtl/memory_access.sv
// MEM stage of the 5-stage MIPS pipeline: byte-addressed data memory with sized,
// little-endian loads/stores, the MEM/WB pipeline register and a debug read port.
module memory_access #(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_enable,
   input  logic               i_WB_write,
   input  logic               i_WB_mem_to_reg,
   input  logic               i_MEM_read,
   input  logic               i_MEM_write,
   input  logic [1:0]         i_MEM_size,
   input  logic               i_MEM_unsigned,
   input  logic [4:0]         i_write_reg,
   input  logic [NB_DATA-1:0] i_ALU_result,
   input  logic [NB_DATA-1:0] i_data_to_write_in_MEM,
   input  logic [NB_ADDR-1:0] i_debug_addr,
   output logic               o_WB_write,
   output logic               o_WB_mem_to_reg,
   output logic [4:0]         o_write_reg,
   output logic [NB_DATA-1:0] o_ALU_result,
   output logic [NB_DATA-1:0] o_mem_data,
   output logic               o_misaligned,
   output logic [NB_DATA-1:0] o_debug_data
);

   localparam int unsigned DEPTH = 2 ** NB_ADDR;

   logic [NB_DATA-1:0] mem_q [DEPTH];

   logic               wb_write_q, wb_mem_to_reg_q, misaligned_q;
   logic [4:0]         write_reg_q;
   logic [NB_DATA-1:0] alu_result_q, mem_data_q, debug_data_q;

   logic [NB_ADDR-1:0] word_idx;
   logic [1:0]         byte_off;
   logic               misaligned, do_store, misaligned_d;
   logic [3:0]         lane_we;
   logic [NB_DATA-1:0] wdata, rword, mem_data_d;
   logic [7:0]         rbyte;
   logic [15:0]        rhalf;

   always_comb begin
      word_idx = i_ALU_result[NB_ADDR+1:2];
      byte_off = i_ALU_result[1:0];

      unique case (i_MEM_size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = byte_off[0];
         default: misaligned = (byte_off != 2'b00);
      endcase

      // Sub-word store data is replicated across lanes so the lane enable alone selects placement.
      unique case (i_MEM_size)
         2'b00: begin
            lane_we = 4'b0001 << byte_off;
            wdata   = {4{i_data_to_write_in_MEM[7:0]}};
         end
         2'b01: begin
            lane_we = byte_off[1] ? 4'b1100 : 4'b0011;
            wdata   = {2{i_data_to_write_in_MEM[15:0]}};
         end
         default: begin
            lane_we = 4'b1111;
            wdata   = i_data_to_write_in_MEM;
         end
      endcase

      do_store     = i_enable & i_MEM_write & ~misaligned;
      misaligned_d = (i_MEM_read | i_MEM_write) & misaligned;

      rword = mem_q[word_idx];
      rbyte = rword[{byte_off, 3'b000} +: 8];
      rhalf = rword[{byte_off[1], 4'b0000} +: 16];

      mem_data_d = '0;
      if (i_MEM_read && !i_MEM_write && !misaligned) begin
         unique case (i_MEM_size)
            2'b00:   mem_data_d = {{(NB_DATA-8){rbyte[7] & ~i_MEM_unsigned}}, rbyte};
            2'b01:   mem_data_d = {{(NB_DATA-16){rhalf[15] & ~i_MEM_unsigned}}, rhalf};
            default: mem_data_d = rword;
         endcase
      end
   end

   // The array is deliberately outside the reset domain; contents survive reset.
   always_ff @(posedge i_clk) begin
      if (do_store) begin
         for (int unsigned k = 0; k < 4; k++) begin
            if (lane_we[k]) mem_q[word_idx][8*k +: 8] <= wdata[8*k +: 8];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         wb_write_q      <= 1'b0;
         wb_mem_to_reg_q <= 1'b0;
         write_reg_q     <= '0;
         alu_result_q    <= '0;
         mem_data_q      <= '0;
         misaligned_q    <= 1'b0;
         debug_data_q    <= '0;
      end else begin
         debug_data_q <= mem_q[i_debug_addr];
         if (i_enable) begin
            wb_write_q      <= i_WB_write;
            wb_mem_to_reg_q <= i_WB_mem_to_reg;
            write_reg_q     <= i_write_reg;
            alu_result_q    <= i_ALU_result;
            mem_data_q      <= mem_data_d;
            misaligned_q    <= misaligned_d;
         end
      end
   end

   assign o_WB_write      = wb_write_q;
   assign o_WB_mem_to_reg = wb_mem_to_reg_q;
   assign o_write_reg     = write_reg_q;
   assign o_ALU_result    = alu_result_q;
   assign o_mem_data      = mem_data_q;
   assign o_misaligned    = misaligned_q;
   assign o_debug_data    = debug_data_q;

endmodule
